// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a word over a valid/ready load
// handshake and shifts it out one bit per clock, streaming words with no gap.
module piso_tx #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] shift_reg, shift_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] d_ordered;
   logic             last_bit;
   logic             accept;

   // Reorder the word once at load so the shifter always drains from its top bit.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_order
         if (MSB_FIRST) begin : g_msb
            assign d_ordered[gi] = d[gi];
         end else begin : g_lsb
            assign d_ordered[gi] = d[WIDTH-1-gi];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      cnt_next   = cnt_reg;

      last_bit   = (state_reg == SHIFT) && (cnt_reg == LAST);
      load_ready = (state_reg == IDLE) || last_bit;
      accept     = load_valid && load_ready;

      busy       = (state_reg == SHIFT);
      sout_valid = busy;
      done       = last_bit;
      sout       = busy & shift_reg[WIDTH-1];

      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = SHIFT;
               shift_next = d_ordered;
               cnt_next   = '0;
            end
         end
         SHIFT: begin
            if (accept) begin
               // Back-to-back reload on the last bit keeps the stream gapless.
               shift_next = d_ordered;
               cnt_next   = '0;
            end else if (last_bit) begin
               state_next = IDLE;
               shift_next = '0;
               cnt_next   = '0;
            end else begin
               shift_next = {shift_reg[WIDTH-2:0], 1'b0};
               cnt_next   = cnt_reg + CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are
// scored against a bit-queue model of the transmitted stream.
module tb_piso_tx;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] d;
   logic         load_valid;

   logic m_rdy, m_sout, m_sv, m_done, m_busy;
   logic l_rdy, l_sout, l_sv, l_done, l_busy;

   int checks = 0;
   int errors = 0;

   piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .load_valid (load_valid),
      .load_ready (m_rdy),
      .sout       (m_sout),
      .sout_valid (m_sv),
      .done       (m_done),
      .busy       (m_busy)
   );

   piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .load_valid (load_valid),
      .load_ready (l_rdy),
      .sout       (l_sout),
      .sout_valid (l_sv),
      .done       (l_done),
      .busy       (l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: queues of bits still to be sent for each bit order.
   bit qm[$];
   bit ql[$];
   bit model_acc;

   task automatic model_clear();
      qm.delete();
      ql.delete();
   endtask

   task automatic model_edge();
      model_acc = 1'b0;
      if (!rst) begin
         model_clear();
      end else begin
         model_acc = load_valid && (qm.size() <= 1);
         if (qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
         end
         if (model_acc) begin
            for (int i = 0; i < W; i++) begin
               qm.push_back(d[W-1-i]);
               ql.push_back(d[i]);
            end
         end
      end
   endtask

   // {sout, sout_valid, done, busy, load_ready} implied by pending bit count.
   function automatic logic [4:0] pack_exp(input int n, input bit f);
      return {(n > 0) ? f : 1'b0, n > 0, n == 1, n > 0, n <= 1};
   endfunction

   function automatic logic [9:0] expected();
      bit fm, fl;
      fm = (qm.size() > 0) ? qm[0] : 1'b0;
      fl = (ql.size() > 0) ? ql[0] : 1'b0;
      return {pack_exp(qm.size(), fm), pack_exp(ql.size(), fl)};
   endfunction

   function automatic logic [9:0] observed();
      return {m_sout, m_sv, m_done, m_busy, m_rdy, l_sout, l_sv, l_done, l_busy, l_rdy};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; d = 4'b1010; load_valid = 1'b1;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (observed() !== 10'b00001_00001) begin
            errors++;
            $display("FAIL reset_hold cyc %0d got %b want %b", i, observed(), 10'b00001_00001);
         end
         tick();
      end
      rst = 1'b1; load_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (observed() !== expected() || m_sv !== 1'b0) begin
            errors++;
            $display("FAIL reset_release cyc %0d got %b want %b", i, observed(), expected());
         end
         tick();
      end
   endtask

   task automatic test_single();
      logic [3:0] seq_m, seq_l, dn;
      seq_m = '0; seq_l = '0; dn = '0;
      d = 4'b1010; load_valid = 1'b1;
      tick();
      load_valid = 1'b0; d = 'x;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL single_out cyc %0d got %b want %b", i, observed(), expected());
         end
         seq_m = {seq_m[2:0], m_sout};
         seq_l = {seq_l[2:0], l_sout};
         dn    = {dn[2:0], m_done};
         tick();
      end
      checks++;
      if (seq_m !== 4'b1010 || seq_l !== 4'b0101 || dn !== 4'b0001) begin
         errors++;
         $display("FAIL single_seq got msb=%b lsb=%b done=%b want msb=1010 lsb=0101 done=0001",
                  seq_m, seq_l, dn);
      end
      @(negedge clk);
      checks++;
      if ({m_busy, m_rdy, l_busy, l_rdy} !== 4'b0101) begin
         errors++;
         $display("FAIL single_after got busy/ready=%b want 0101", {m_busy, m_rdy, l_busy, l_rdy});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq_m, seq_l, dn;
      seq_m = '0; seq_l = '0; dn = '0;
      d = 4'b1100; load_valid = 1'b1;
      tick();
      d = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL b2b_out cyc %0d got %b want %b", i, observed(), expected());
         end
         seq_m = {seq_m[6:0], m_sout & m_sv};
         seq_l = {seq_l[6:0], l_sout & l_sv};
         dn    = {dn[6:0], m_done};
         tick();
         if (model_acc) load_valid = 1'b0;
      end
      load_valid = 1'b0;
      checks++;
      if (seq_m !== 8'b1100_1111 || seq_l !== 8'b0011_1111 || dn !== 8'b0001_0001) begin
         errors++;
         $display("FAIL b2b_seq got msb=%b lsb=%b done=%b want 11001111 00111111 00010001",
                  seq_m, seq_l, dn);
      end
   endtask

   task automatic test_ignored_load();
      logic [3:0] seq_m, seq_l;
      seq_m = '0; seq_l = '0;
      d = 4'b1100; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            d = 4'b0011; load_valid = 1'b1;
         end
         @(negedge clk);
         checks++;
         if (observed() !== expected() || (i == 1 && m_rdy !== 1'b0)) begin
            errors++;
            $display("FAIL ignored_out cyc %0d got %b want %b", i, observed(), expected());
         end
         seq_m = {seq_m[2:0], m_sout};
         seq_l = {seq_l[2:0], l_sout};
         tick();
         load_valid = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (observed() !== expected() || m_sv !== 1'b0) begin
            errors++;
            $display("FAIL ignored_idle cyc %0d got %b want %b", i, observed(), expected());
         end
         tick();
      end
      checks++;
      if (seq_m !== 4'b1100 || seq_l !== 4'b0011) begin
         errors++;
         $display("FAIL ignored_seq got msb=%b lsb=%b want 1100 0011", seq_m, seq_l);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [3:0] seq_m, seq_l, dn;
      seq_m = '0; seq_l = '0; dn = '0;
      d = 4'b1111; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL midrst_pre cyc %0d got %b want %b", i, observed(), expected());
         end
         tick();
      end
      rst = 1'b0;
      model_clear();
      #1;
      checks++;
      if ({m_sv, m_busy, m_done, l_sv, l_busy, l_done} !== 6'b0 || observed() !== expected()) begin
         errors++;
         $display("FAIL midrst_async got %b want %b", observed(), expected());
      end
      tick();
      tick();
      rst = 1'b1; d = 4'b0011; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL midrst_post cyc %0d got %b want %b", i, observed(), expected());
         end
         seq_m = {seq_m[2:0], m_sout};
         seq_l = {seq_l[2:0], l_sout};
         dn    = {dn[2:0], m_done};
         tick();
      end
      checks++;
      if (seq_m !== 4'b0011 || seq_l !== 4'b1100 || dn !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_seq got msb=%b lsb=%b done=%b want 0011 1100 0001", seq_m, seq_l, dn);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b0;
            load_valid = 1'b0;
            model_clear();
         end else begin
            rst = 1'b1;
            if (!load_valid || model_acc) begin
               load_valid = ($urandom_range(0, 2) != 0);
               d = W'($urandom);
            end
         end
         @(negedge clk);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("FAIL random_out cyc %0d got %b want %b", i, observed(), expected());
         end
         tick();
      end
      rst = 1'b1;
      load_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; d = '0; load_valid = 1'b0; model_acc = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_ignored_load();
      test_reset_mid_word();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter. It is the read/transmit side of the team's parallel data register. It accepts a WIDTH-bit word (typically the q output of a parallel register) through a valid/ready load handshake. It then shifts the word out one bit per clock on a serial line with a qualifying valid strobe, and pulses done on the final bit. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 4, data word width in bits (>= 2).
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
d  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
load_valid  input  1  source has a word on d.
load_ready  output  1  transmitter can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a valid data bit this cycle.
done  output  1  one-cycle pulse coincident with the last bit of a word.
busy  output  1  transmitter is in SHIFT.

Behaviour:
- Reset (rst=0), asynchronous and effective immediately:
  - state=IDLE, shift register=0, bit counter=0.
  - Registered outputs go to sout=0, sout_valid=0, done=0, busy=0.
  - load_ready=1 while rst=0 (it follows the IDLE state), but no load is accepted while rst=0.
- Reset release: the first capturing edge is the first rising clk with rst=1.
- States: IDLE, SHIFT.
- Load accept: a word is accepted on a rising edge where load_valid=1, load_ready=1 and rst=1. On that edge:
  - d is copied into the shift register.
  - counter is set to 0 and state goes to SHIFT.
- load_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only during the last-bit cycle (counter==WIDTH-1).
  - 0 otherwise.
- Latency: a word accepted at edge N appears on sout in the cycles after edges N .. N+WIDTH-1. sout_valid=1 for exactly WIDTH consecutive cycles.
- Bit order:
  - MSB_FIRST=1: d[WIDTH-1] first, d[0] last.
  - MSB_FIRST=0: d[0] first, d[WIDTH-1] last.
- sout is registered (or driven from the registered shift register). sout=0 whenever sout_valid=0.
- Counter: increments once per SHIFT cycle, width $clog2(WIDTH). On the last-bit cycle:
  - done=1 (exactly one cycle).
  - At the next edge, with no new load, go to IDLE and clear the counter.
- Back-to-back: if load_valid=1 during the last-bit cycle, the new word is accepted on that edge. State stays SHIFT, counter reloads to 0, and the first bit of the new word follows the last bit of the old one with no gap. done pulses once per word.
- load_valid=1 in SHIFT before the last-bit cycle has no effect; d is not sampled. The source must hold load_valid and d until accepted.
- busy=1 exactly when state=SHIFT (busy equals sout_valid).
- Reset mid-word: the partial word is discarded, all outputs drop to reset values at once, and no done pulse is generated.
- No X propagation: d is only sampled on accept, so X on d while not loading must not reach sout.

Test Plan:
1. Reset hold: rst=0, d=4'b1010, load_valid=1 for 3 clocks -> sout_valid=0, sout=0, busy=0, done=0 throughout; no word transmitted after release unless load_valid is still high.
2. Single word, MSB_FIRST=1: load 4'b1010 -> over 4 cycles sout=1,0,1,0 with sout_valid=1; done=1 only on the 4th bit; next cycle busy=0, load_ready=1.
3. Back-to-back: present 4'b1100, then 4'b1111 with load_valid held through the last bit of the first word -> 8 contiguous valid bits 1,1,0,0,1,1,1,1 with no gap; done pulses on bits 4 and 8.
4. Ignored load: during bit 2 of 4'b1100, drive d=4'b0011 with load_valid=1 for one cycle, then drop it -> output stays 1,1,0,0; load_ready=0 on that cycle; the 0011 word is never sent.
5. Reset mid-word: load 4'b1111, assert rst=0 asynchronously after bit 2 -> sout_valid and busy fall before the next clk edge, no done. Release, load 4'b0011 -> sout=0,0,1,1 with done on the 4th bit.
6. LSB-first instance (MSB_FIRST=0): load 4'b1010 -> sout=0,1,0,1; done on the 4th bit.
